// File: rtl/accumulate_fifo_if.sv
// Write/read slave bus bundle for accumulate_fifo.
interface accumulate_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 3
);
    logic [2*DATA_WIDTH-1:0] writedata;
    logic                    write;
    logic                    write_waitrequest;
    logic                    read;
    logic [2*DATA_WIDTH-1:0] readdata;
    logic                    read_waitrequest;
    logic [DEPTH_LOG2:0]     level;

    modport slave (
        input  writedata, write, read,
        output write_waitrequest, readdata, read_waitrequest, level
    );

    modport master (
        output writedata, write, read,
        input  write_waitrequest, readdata, read_waitrequest, level
    );
endinterface

// File: rtl/accumulate_fifo.sv
// Coalescing key/value FIFO: updates to an already-queued key add into that
// entry, new keys append at the tail; entries drain in allocation order.
// Optional: define ACCUMULATE_FIFO_SATURATE_EN to clamp hit sums at all-ones
// instead of wrapping.
module accumulate_fifo #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    accumulate_fifo_if.slave  bus
);
    localparam int unsigned DEPTH = 2**DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    logic                  valid_q [DEPTH];
    logic [DATA_WIDTH-1:0] key_q   [DEPTH];
    logic [DATA_WIDTH-1:0] val_q   [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q;
    logic [DEPTH_LOG2-1:0] tail_q;
    logic [LW-1:0]         count_q;

    logic [DATA_WIDTH-1:0] wkey_c;
    logic [DATA_WIDTH-1:0] wval_c;
    logic                  wr_en_c;
    logic                  rd_en_c;
    logic                  hit_c;
    logic [DEPTH_LOG2-1:0] hit_idx_c;
    logic                  wr_miss_c;
    logic [DATA_WIDTH-1:0] sum_c;
    logic [LW-1:0]         count_next_c;

    assign wkey_c = bus.writedata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign wval_c = bus.writedata[DATA_WIDTH-1:0];

    // Accept strobes, gated by the registered occupancy flags
    assign wr_en_c = bus.write && !bus.write_waitrequest;
    assign rd_en_c = bus.read  && !bus.read_waitrequest;

    // Key match against live entries; the entry popped this cycle is already committed
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (key_q[i] == wkey_c) &&
                !(rd_en_c && (DEPTH_LOG2'(i) == head_q))) begin
                hit_c     = 1'b1;
                hit_idx_c = DEPTH_LOG2'(i);
            end
        end
    end

`ifdef ACCUMULATE_FIFO_SATURATE_EN
    logic [DATA_WIDTH:0] sum_full_c;

    // Widened add, clamped to all-ones on carry out
    always_comb begin
        sum_full_c = {1'b0, val_q[hit_idx_c]} + {1'b0, wval_c};
        sum_c      = sum_full_c[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum_full_c[DATA_WIDTH-1:0];
    end
`else
    // Modulo add
    always_comb begin
        sum_c = val_q[hit_idx_c] + wval_c;
    end
`endif

    // Next occupancy: a miss grows the table, a pop shrinks it
    always_comb begin
        wr_miss_c    = wr_en_c && !hit_c;
        count_next_c = count_q + LW'(wr_miss_c) - LW'(rd_en_c);
    end

    // Entry storage, pointers, occupancy flags and read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                key_q[i]   <= '0;
                val_q[i]   <= '0;
            end
            head_q                <= '0;
            tail_q                <= '0;
            count_q               <= '0;
            bus.readdata          <= '0;
            bus.write_waitrequest <= 1'b0;
            bus.read_waitrequest  <= 1'b1;
        end else begin
            if (rd_en_c) begin
                bus.readdata    <= {key_q[head_q], val_q[head_q]};
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + DEPTH_LOG2'(1);
            end
            if (wr_en_c) begin
                if (hit_c) begin
                    val_q[hit_idx_c] <= sum_c;
                end else begin
                    valid_q[tail_q] <= 1'b1;
                    key_q[tail_q]   <= wkey_c;
                    val_q[tail_q]   <= wval_c;
                    tail_q          <= tail_q + DEPTH_LOG2'(1);
                end
            end
            count_q               <= count_next_c;
            bus.write_waitrequest <= (count_next_c == LW'(DEPTH));
            bus.read_waitrequest  <= (count_next_c == '0);
        end
    end

    assign bus.level = count_q;
endmodule

// File: tb/tb_accumulate_fifo.sv
// Directed bench for accumulate_fifo: vector table plus full-table and
// mid-operation reset sequences.
module tb_accumulate_fifo;
    logic clk;
    logic reset;

    accumulate_fifo_if #(.DATA_WIDTH(32), .DEPTH_LOG2(3)) bus ();

    accumulate_fifo #(.DEPTH_LOG2(3), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ACCUMULATE_FIFO_SATURATE_EN
    localparam logic [31:0] SAT_EXP = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] SAT_EXP = 32'h0000_0010;
`endif

    typedef struct {
        logic        wr;
        logic [63:0] wdata;
        logic        rd;
        logic [3:0]  level;
        logic        wwait;
        logic        rwait;
        logic [63:0] rdata;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    int n_applied;
    int n_miss;

    function automatic vec_t mk(logic wr, logic [31:0] k, logic [31:0] v, logic rd,
                                int lvl, logic ww, logic rw, logic [31:0] rk, logic [31:0] rv);
        vec_t t;
        t.wr    = wr;
        t.wdata = {k, v};
        t.rd    = rd;
        t.level = 4'(lvl);
        t.wwait = ww;
        t.rwait = rw;
        t.rdata = {rk, rv};
        return t;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, int lvl, logic ww, logic rw, logic [63:0] rd);
        check({tag, ".level"}, 64'(bus.level), 64'(lvl));
        check({tag, ".wwait"}, 64'(bus.write_waitrequest), 64'(ww));
        check({tag, ".rwait"}, 64'(bus.read_waitrequest), 64'(rw));
        check({tag, ".rdata"}, bus.readdata, rd);
    endtask

    // One clock with the given strobes; outputs sampled on the following falling edge
    task automatic step(logic wr, logic [63:0] wd, logic rd);
        bus.write     = wr;
        bus.writedata = wd;
        bus.read      = rd;
        @(negedge clk);
        bus.write = 1'b0;
        bus.read  = 1'b0;
    endtask

    initial begin
        n_applied = 0;
        n_miss    = 0;
        bus.write     = 1'b0;
        bus.read      = 1'b0;
        bus.writedata = '0;
        reset         = 1'b1;

        vecs[0]  = mk(1, 5, 10,          0, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0,           1, 0, 0, 1, 5, 10);
        vecs[2]  = mk(1, 7, 3,           0, 1, 0, 0, 5, 10);
        vecs[3]  = mk(1, 7, 4,           0, 1, 0, 0, 5, 10);
        vecs[4]  = mk(1, 9, 1,           0, 2, 0, 0, 5, 10);
        vecs[5]  = mk(0, 0, 0,           1, 1, 0, 0, 7, 7);
        vecs[6]  = mk(0, 0, 0,           1, 0, 0, 1, 9, 1);
        vecs[7]  = mk(0, 0, 0,           1, 0, 0, 1, 9, 1);
        vecs[8]  = mk(1, 2, 6,           0, 1, 0, 0, 9, 1);
        vecs[9]  = mk(1, 2, 1,           1, 1, 0, 0, 2, 6);
        vecs[10] = mk(0, 0, 0,           1, 0, 0, 1, 2, 1);
        vecs[11] = mk(1, 3, 32'hFFFF_FFF0, 0, 1, 0, 0, 2, 1);
        vecs[12] = mk(1, 3, 32'h20,      0, 1, 0, 0, 2, 1);
        vecs[13] = mk(0, 0, 0,           1, 0, 0, 1, 3, SAT_EXP);
        vecs[14] = mk(1, 4, 1,           0, 1, 0, 0, 3, SAT_EXP);
        vecs[15] = mk(1, 6, 2,           0, 2, 0, 0, 3, SAT_EXP);
        vecs[16] = mk(1, 6, 3,           1, 1, 0, 0, 4, 1);
        vecs[17] = mk(0, 0, 0,           1, 0, 0, 1, 6, 5);

        // Reset state
        @(negedge clk);
        check_all("reset", 0, 0, 1, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].wr, vecs[i].wdata, vecs[i].rd);
            check_all($sformatf("vec%0d", i), int'(vecs[i].level), vecs[i].wwait,
                      vecs[i].rwait, vecs[i].rdata);
        end

        // Fill all 8 entries with distinct keys
        for (int i = 0; i < 8; i++) step(1'b1, {32'h10 + 32'(i), 32'(i)}, 1'b0);
        check_all("full", 8, 1, 0, {32'd6, 32'd5});
        step(1'b1, {32'h20, 32'd5}, 1'b0);
        check_all("full_new_held", 8, 1, 0, {32'd6, 32'd5});
        step(1'b1, {32'h10, 32'd100}, 1'b0);
        check_all("full_hit_held", 8, 1, 0, {32'd6, 32'd5});
        // Read frees a slot, but the same-cycle write is still blocked
        step(1'b1, {32'h20, 32'd5}, 1'b1);
        check_all("full_pop", 7, 0, 0, {32'h10, 32'd0});
        step(1'b1, {32'h20, 32'd5}, 1'b0);
        check_all("refill", 8, 1, 0, {32'h10, 32'd0});
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 64'h0, 1'b1);
            check($sformatf("drain%0d", i), bus.readdata, {32'h10 + 32'(i), 32'(i)});
        end
        step(1'b0, 64'h0, 1'b1);
        check_all("drain_last", 0, 0, 1, {32'h20, 32'd5});

        // Reset with 4 queued entries takes effect without a clock edge
        for (int i = 0; i < 4; i++) step(1'b1, {32'h40 + 32'(i), 32'd1}, 1'b0);
        check_all("pre_reset", 4, 0, 0, {32'h20, 32'd5});
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 0, 0, 1, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 64'h0, 1'b1);
        check_all("post_reset_read", 0, 0, 1, 64'h0);
        step(1'b1, {32'h41, 32'd9}, 1'b0);
        step(1'b0, 64'h0, 1'b1);
        check_all("post_reset_fresh", 0, 0, 1, {32'h41, 32'd9});

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end
endmodule
